// File: rtl/keypad_auth_initiator_pkg.sv
// Shared types, default constants and width helpers for the keypad authorization initiator.
package keypad_auth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GRANT,
    S_LOCKOUT
  } auth_state_t;

  localparam int DEFAULT_CODE_W         = 4;
  localparam int DEFAULT_RESP_DELAY     = 1;
  localparam int DEFAULT_UNLOCK_CYCLES  = 8;
  localparam int DEFAULT_MAX_FAILS      = 3;
  localparam int DEFAULT_LOCKOUT_CYCLES = 16;
  localparam int DEFAULT_ENTRY_TIMEOUT  = 32;

  function automatic int fail_cnt_w(input int max_fails);
    return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
  endfunction

  // One timer serves WAIT, GRANT and LOCKOUT, so it must hold the longest of the three.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/keypad_auth_initiator_if.sv
// Request/response bus between the keypad initiator and the AuthorizationSystem.
interface keypad_auth_initiator_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] code;
  logic              validate;
  logic              auth_status;

  modport master (output code, output validate, input auth_status);
  modport slave  (input code, input validate, output auth_status);
endinterface

// File: rtl/keypad_auth_initiator_timer.sv
// auth_cycle_timer: loadable down-counter; done marks the last cycle of the loaded span.
module auth_cycle_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/keypad_auth_initiator.sv
// Keypad-side initiator: digit capture, validate request, unlock window, failure lockout.
// Optional KEYPAD_TIMEOUT_EN discards a loaded digit after ENTRY_TIMEOUT idle cycles.
module keypad_auth_initiator
  import keypad_auth_pkg::*;
#(
  parameter int CODE_W         = DEFAULT_CODE_W,
  parameter int RESP_DELAY     = DEFAULT_RESP_DELAY,
  parameter int UNLOCK_CYCLES  = DEFAULT_UNLOCK_CYCLES,
  parameter int MAX_FAILS      = DEFAULT_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
  parameter int ENTRY_TIMEOUT  = DEFAULT_ENTRY_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                key_valid,
  input  logic [CODE_W-1:0]                   key_digit,
  input  logic                                key_enter,
  input  logic                                key_clear,
  keypad_auth_initiator_if.master             auth,
  output logic                                door_unlock,
  output logic                                locked_out,
  output logic [fail_cnt_w(MAX_FAILS)-1:0]    fail_count,
  output logic                                busy
);
  localparam int FC_W  = fail_cnt_w(MAX_FAILS);
  localparam int TMR_W = timer_w(RESP_DELAY, UNLOCK_CYCLES, LOCKOUT_CYCLES);

  if (RESP_DELAY < 1 || UNLOCK_CYCLES < 1 || MAX_FAILS < 1 ||
      LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT < 1) begin : g_bad_params
    $error("keypad_auth_initiator: timing parameters must be >= 1");
  end

  auth_state_t        state;
  logic               loaded;
  logic [CODE_W-1:0]  held;
  logic [CODE_W-1:0]  code_r;
  logic               validate_r;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;
  logic               entry_expired;
  logic               any_key;

  assign auth.code     = code_r;
  assign auth.validate = validate_r;
  assign any_key       = key_valid | key_enter | key_clear;

  // Timer is loaded on the edge that enters WAIT, GRANT or LOCKOUT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state == S_SEND) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(RESP_DELAY);
    end else if (state == S_WAIT && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = auth.auth_status ? TMR_W'(UNLOCK_CYCLES) : TMR_W'(LOCKOUT_CYCLES);
    end
  end

  auth_cycle_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TO_W = $clog2(ENTRY_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_IDLE || !loaded || any_key) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign entry_expired = (state == S_IDLE) && loaded && !any_key &&
                         (idle_cnt == TO_W'(ENTRY_TIMEOUT - 1));
`else
  assign entry_expired = 1'b0;
`endif

  // Digit holding register carries data only; the loaded flag qualifies it.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && key_valid && !key_enter && !key_clear) begin
      held <= key_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      loaded      <= 1'b0;
      code_r      <= '0;
      validate_r  <= 1'b0;
      door_unlock <= 1'b0;
      locked_out  <= 1'b0;
      fail_count  <= '0;
      busy        <= 1'b0;
    end else begin
      validate_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_clear) begin
            loaded <= 1'b0;
          end else if (key_enter) begin
            if (loaded) begin
              state      <= S_SEND;
              code_r     <= held;
              validate_r <= 1'b1;
              busy       <= 1'b1;
            end
          end else if (key_valid) begin
            loaded <= 1'b1;
          end else if (entry_expired) begin
            loaded <= 1'b0;
          end
        end
        S_SEND: begin
          state  <= S_WAIT;
          loaded <= 1'b0;
        end
        S_WAIT: begin
          if (tmr_done) begin
            if (auth.auth_status) begin
              fail_count  <= '0;
              door_unlock <= 1'b1;
              state       <= S_GRANT;
            end else if (fail_count == FC_W'(MAX_FAILS - 1)) begin
              fail_count <= FC_W'(MAX_FAILS);
              locked_out <= 1'b1;
              state      <= S_LOCKOUT;
            end else begin
              fail_count <= fail_count + FC_W'(1);
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        S_GRANT: begin
          if (tmr_done) begin
            door_unlock <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (tmr_done) begin
            locked_out <= 1'b0;
            fail_count <= '0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
